// File: rtl/ct_field_conv_pipe.sv
// ct_field_conv_pipe: a registered field converter on a ready/valid stream.
// The incoming field is translated through a parameter table. When several
// entries match, the lowest index wins. A miss yields DEFAULT_OF, or the beat
// is dropped when DROP_MISS is set. The data word travels with the field.
// Valid/data are registered through an output slot plus one skid slot, and
// o_ready is registered too, so both directions of the timing path are cut.
// Optional build macro CT_FIELD_CONV_PIPE_STATS_EN enables the saturating
// miss counter. Without it, o_miss_count reads 0 and i_stats_clr is ignored.
module ct_field_conv_pipe #(
    parameter int                       WD         = 32,
    parameter int                       WIF        = 4,
    parameter int                       WOF        = 4,
    parameter int                       N_ENTRIES  = 4,
    parameter logic [WIF*N_ENTRIES-1:0] IF         = {4'd3, 4'd2, 4'd1, 4'd0},
    parameter logic [WOF*N_ENTRIES-1:0] OF         = {4'd8, 4'd4, 4'd2, 4'd1},
    parameter logic [WOF-1:0]           DEFAULT_OF = '0,
    parameter bit                       DROP_MISS  = 1'b0,
    parameter int                       CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WD-1:0]    i_data,
    input  logic [WIF-1:0]   i_field,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WD-1:0]    o_data,
    output logic [WOF-1:0]   o_field,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_stats_clr,
    output logic [CNT_W-1:0] o_miss_count
);

    logic [WOF-1:0] field_p0;
    logic           hit_p0;
    logic           in_fire;
    logic           out_fire;
    logic           in_keep;
    logic           load_skid;
    logic           load_in;
    logic           to_skid;
    logic           out_vld_nxt;
    logic           skid_vld_nxt;
    logic           skid_vld_p1;
    logic [WD-1:0]  skid_data_p1;
    logic [WOF-1:0] skid_field_p1;

    // Stage p0: table lookup. The descending scan lets the lowest matching index win.
    always_comb begin
        field_p0 = DEFAULT_OF;
        hit_p0   = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (IF[WIF*i +: WIF] == i_field) begin
                field_p0 = OF[WOF*i +: WOF];
                hit_p0   = 1'b1;
            end
        end
    end

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign in_keep  = in_fire & (hit_p0 | ~DROP_MISS);

    // Slot steering: refill the output slot (skid first), then park a kept beat in skid.
    always_comb begin
        out_vld_nxt  = o_valid;
        skid_vld_nxt = skid_vld_p1;
        load_skid    = 1'b0;
        load_in      = 1'b0;
        to_skid      = 1'b0;
        if (!o_valid || out_fire) begin
            if (skid_vld_p1) begin
                load_skid    = 1'b1;
                out_vld_nxt  = 1'b1;
                skid_vld_nxt = 1'b0;
            end else if (in_keep) begin
                load_in     = 1'b1;
                out_vld_nxt = 1'b1;
            end else begin
                out_vld_nxt = 1'b0;
            end
        end
        if (in_keep && out_vld_nxt && !load_in) begin
            to_skid      = 1'b1;
            skid_vld_nxt = 1'b1;
        end
    end

    // Stage p1: output slot and handshake state. o_ready mirrors the next skid vacancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid     <= 1'b0;
            o_ready     <= 1'b0;
            skid_vld_p1 <= 1'b0;
            o_data      <= '0;
            o_field     <= '0;
        end else begin
            o_valid     <= out_vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            o_ready     <= ~skid_vld_nxt;
            if (load_skid) begin
                o_data  <= skid_data_p1;
                o_field <= skid_field_p1;
            end else if (load_in) begin
                o_data  <= i_data;
                o_field <= field_p0;
            end
        end
    end

    // Skid payload is only meaningful while skid_vld_p1 is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (to_skid) begin
            skid_data_p1  <= i_data;
            skid_field_p1 <= field_p0;
        end
    end

`ifdef CT_FIELD_CONV_PIPE_STATS_EN
    logic [CNT_W-1:0] miss_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Miss statistics: clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_cnt <= '0;
        end else if (i_stats_clr) begin
            miss_cnt <= '0;
        end else if (in_fire && !hit_p0) begin
            miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign o_miss_count = miss_cnt;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = i_stats_clr;
    assign o_miss_count     = '0;
`endif

endmodule

// File: doc/ct_field_conv_pipe.md
Name: ct_field_conv_pipe

Overview:
- Registered, full-throughput successor to the combinational field converter on ready/valid streams.
- Translates an input field to an output field through a parameter table, with defined priority on multiple matches, a default value on a miss, and optional drop-on-miss.
- Passthrough data travels alongside the field.
- Sits between switch/arbiter stages where the converter must break the timing path in both the valid/data and the ready directions.

Parameters:
- WD, 32, width of passthrough data (excluding fields)
- WIF, 4, width of input field
- WOF, 4, width of output field
- N_ENTRIES, 4, number of table pairs
- IF, {4'd3,4'd2,4'd1,4'd0}, input field values; entry i at [WIF*i +: WIF]
- OF, {4'd8,4'd4,4'd2,4'd1}, output field values; entry i at [WOF*i +: WOF]
- DEFAULT_OF, 0, output field emitted on a miss (WOF bits)
- DROP_MISS, 0, 1 = accept and discard beats whose input field misses the table
- CNT_W, 16, width of the miss counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-low (asserted at 0)
- i_data  input  WD  upstream passthrough data
- i_field  input  WIF  upstream field
- i_valid  input  1  upstream valid
- o_ready  output  1  ready to upstream (registered)
- o_data  output  WD  downstream data (registered)
- o_field  output  WOF  downstream converted field (registered)
- o_valid  output  1  downstream valid (registered)
- i_ready  input  1  downstream ready
- i_stats_clr  input  1  synchronous clear of the miss counter
- o_miss_count  output  CNT_W  saturating miss count

Behaviour:
- Reset (reset=0, asynchronous): o_valid=0, o_data=0, o_field=0, skid slot empty, o_ready=1 from the first edge after release (0 while reset is asserted), o_miss_count=0.
- Lookup is combinational on i_field. The lowest index i with IF[i]==i_field wins. If no entry matches, the beat is a miss and the result is DEFAULT_OF.
- in_fire = i_valid & o_ready. out_fire = o_valid & i_ready.
- Storage: output slot (o_*) plus one skid slot. Converted field and data are stored together.
- o_ready is registered; it equals the inverse of the next-cycle skid-slot occupancy and has no combinational dependence on i_ready.
- Per-clock transfer, applied in order:
  1. If the output slot is empty or out_fire: load the output slot from the skid slot if it is occupied (skid becomes empty), else from the input beat if in_fire and not dropped; otherwise o_valid becomes 0.
  2. If in_fire, the beat is not dropped, and the output slot stays occupied (holding a beat, or just loaded from skid): the beat goes to the skid slot.
- Latency: 1 cycle from in_fire to o_valid when the output path is free. Sustained throughput: 1 beat/cycle with i_ready=1.
- Skid full implies o_ready=0 the next cycle. The skid slot never overflows. Simultaneous in_fire and out_fire with skid full cannot occur.
- DROP_MISS=1: a missing beat is consumed (in_fire occurs) but never appears downstream and never occupies any slot.
- o_data, o_field, o_valid hold stable while o_valid=1 and i_ready=0.
- Miss counter: increments by 1 on each in_fire with a miss, saturating at 2^CNT_W-1. i_stats_clr forces 0 and takes priority over a same-cycle increment.
- reset asserted mid-transfer: all held beats are lost. No partial state is retained.

Optional Feature:
- Macro: CT_FIELD_CONV_PIPE_STATS_EN.
- Defined: miss counter and i_stats_clr are implemented as described.
- Undefined: the counter logic is omitted, o_miss_count is tied to 0, and i_stats_clr is ignored. Datapath behaviour is identical in both builds.

Test Plan:
- Stream i_field 0,1,2,3 back-to-back with i_ready=1 -> o_field 1,2,4,8 on consecutive cycles, each one cycle after acceptance; data preserved.
- Set IF={4'd5,4'd5,4'd1,4'd0}, send i_field=5 -> o_field=4 (entry 2, lowest matching index wins); i_field=9 with DEFAULT_OF=4'hF -> o_field=F, o_miss_count=1.
- Drive i_ready=0 while sending 3 beats -> 2 accepted (output slot + skid), o_ready=0 thereafter; release i_ready -> beats emerge in order, no loss or duplication, o_ready returns to 1.
- DROP_MISS=1, send fields 0,9,1 -> downstream sees only 1,2; all three accepted; o_miss_count=1.
- CNT_W=2, send 5 misses -> o_miss_count saturates at 3; pulse i_stats_clr together with a miss -> 0.
- Assert reset with both slots full -> o_valid=0 immediately; after release o_ready=1 and no stale beats appear.
